// File: rtl/fft16_pkg.sv
// fft16_pkg: constants and types shared by the 16-point FFT input/output
// converters.
//   FFT_WIDTH  : real/imag sample width
//   FFT_POINTS : complex samples per frame
//   S2P_BEATS  : beats per frame (two complex samples per beat)
package fft16_pkg;

  localparam int unsigned FFT_WIDTH  = 17;
  localparam int unsigned FFT_POINTS = 16;
  localparam int unsigned S2P_BEATS  = 8;

  typedef enum logic {
    S2P_IDLE,
    S2P_FILL
  } s2p_state_t;

  // One-hot write-enable for the slot pair addressed by a beat index.
  function automatic logic [S2P_BEATS-1:0] beat_onehot(input logic [2:0] beat);
    beat_onehot       = '0;
    beat_onehot[beat] = 1'b1;
  endfunction

endpackage

// File: rtl/ser2par_if.sv
// ser2par_if: input beat stream of the FFT deserializer.
//   valid_i              beat qualifier
//   sof_i                start of frame (beat 0), qualified by valid_i
//   data_i0_R/data_i0_I  sample x[b]
//   data_i1_R/data_i1_I  sample x[b+8]
// master: stream source, slave: ser2par.
interface ser2par_if
  import fft16_pkg::*;
#(
  parameter int unsigned WIDTH = FFT_WIDTH
);

  logic             valid_i;
  logic             sof_i;
  logic [WIDTH-1:0] data_i0_R;
  logic [WIDTH-1:0] data_i0_I;
  logic [WIDTH-1:0] data_i1_R;
  logic [WIDTH-1:0] data_i1_I;

  modport master (
    output valid_i, sof_i, data_i0_R, data_i0_I, data_i1_R, data_i1_I
  );

  modport slave (
    input  valid_i, sof_i, data_i0_R, data_i0_I, data_i1_R, data_i1_I
  );

endinterface

// File: rtl/ser2par_ctrl.sv
// ser2par_ctrl: frame-assembly control for ser2par.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_valid, i_sof  beat qualifier and start-of-frame
//   o_we            one-hot write enable over the 8 shadow slot pairs
//   o_xfer          shadow -> output bank transfer strobe (8th beat)
//   o_frame_valid   registered one-cycle pulse, new frame in output bank
//   o_sof_err       registered one-cycle pulse, frame restarted mid-fill
//   o_beat          registered index the next valid beat is written to
module ser2par_ctrl
  import fft16_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_sof,
  output logic [S2P_BEATS-1:0] o_we,
  output logic                 o_xfer,
  output logic                 o_frame_valid,
  output logic                 o_sof_err,
  output logic [2:0]           o_beat
);

  s2p_state_t r_state;
  logic [2:0] r_beat;
  logic       r_frame_valid;
  logic       r_sof_err;

  logic w_start;
  logic w_acc;

  // A sof beat always (re)starts at beat 0; a plain beat is only taken mid-fill.
  assign w_start = i_valid & i_sof;
  assign w_acc   = i_valid & ~i_sof & (r_state == S2P_FILL);

  always_comb begin
    o_we = '0;
    if (w_start) begin
      o_we = beat_onehot(3'd0);
    end else if (w_acc) begin
      o_we = beat_onehot(r_beat);
    end
  end

  assign o_xfer = w_acc && (r_beat == 3'(S2P_BEATS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S2P_IDLE;
      r_beat        <= '0;
      r_frame_valid <= 1'b0;
      r_sof_err     <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_sof_err     <= 1'b0;
      case (r_state)
        S2P_IDLE: begin
          if (w_start) begin
            r_beat  <= 3'd1;
            r_state <= S2P_FILL;
          end
        end
        S2P_FILL: begin
          if (w_start) begin
            r_sof_err <= 1'b1;
            r_beat    <= 3'd1;
          end else if (w_acc) begin
            if (r_beat == 3'(S2P_BEATS - 1)) begin
              r_frame_valid <= 1'b1;
              r_beat        <= '0;
              r_state       <= S2P_IDLE;
            end else begin
              r_beat <= r_beat + 3'd1;
            end
          end
        end
        default: begin
          r_state <= S2P_IDLE;
          r_beat  <= '0;
        end
      endcase
    end
  end

  assign o_frame_valid = r_frame_valid;
  assign o_sof_err     = r_sof_err;
  assign o_beat        = r_beat;

endmodule

// File: rtl/ser2par.sv
// ser2par: input-side deserializer for the 16-point FFT.
//   clk, rst_n          clock, async active-low reset
//   s_in                beat stream (ser2par_if.slave); beat b carries x[b], x[b+8]
//   data_oN_R/I         assembled frame sample x[N], held until next frame
//   frame_valid_o       one-cycle pulse, new frame on data_o*
//   beat_o              next beat index expected (0 = waiting for sof)
//   sof_err_o           one-cycle pulse, frame restarted by sof mid-frame
module ser2par
  import fft16_pkg::*;
#(
  parameter int unsigned WIDTH = FFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  ser2par_if.slave         s_in,
  output logic [WIDTH-1:0] data_o0_R,  data_o0_I,
  output logic [WIDTH-1:0] data_o1_R,  data_o1_I,
  output logic [WIDTH-1:0] data_o2_R,  data_o2_I,
  output logic [WIDTH-1:0] data_o3_R,  data_o3_I,
  output logic [WIDTH-1:0] data_o4_R,  data_o4_I,
  output logic [WIDTH-1:0] data_o5_R,  data_o5_I,
  output logic [WIDTH-1:0] data_o6_R,  data_o6_I,
  output logic [WIDTH-1:0] data_o7_R,  data_o7_I,
  output logic [WIDTH-1:0] data_o8_R,  data_o8_I,
  output logic [WIDTH-1:0] data_o9_R,  data_o9_I,
  output logic [WIDTH-1:0] data_o10_R, data_o10_I,
  output logic [WIDTH-1:0] data_o11_R, data_o11_I,
  output logic [WIDTH-1:0] data_o12_R, data_o12_I,
  output logic [WIDTH-1:0] data_o13_R, data_o13_I,
  output logic [WIDTH-1:0] data_o14_R, data_o14_I,
  output logic [WIDTH-1:0] data_o15_R, data_o15_I,
  output logic             frame_valid_o,
  output logic [2:0]       beat_o,
  output logic             sof_err_o
);

  logic [S2P_BEATS-1:0] w_we;
  logic                 w_xfer;

  ser2par_ctrl u_ctrl (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (s_in.valid_i),
    .i_sof         (s_in.sof_i),
    .o_we          (w_we),
    .o_xfer        (w_xfer),
    .o_frame_valid (frame_valid_o),
    .o_sof_err     (sof_err_o),
    .o_beat        (beat_o)
  );

  for (genvar n = 0; n < FFT_POINTS; n++) begin : g_slot
    localparam logic [2:0] PAIR = 3'(n % S2P_BEATS);
    localparam bit         HI   = (n >= S2P_BEATS);

    logic [WIDTH-1:0] w_in_R, w_in_I;
    logic [WIDTH-1:0] r_sh_R, r_sh_I;
    logic [WIDTH-1:0] r_bank_R, r_bank_I;

    assign w_in_R = HI ? s_in.data_i1_R : s_in.data_i0_R;
    assign w_in_I = HI ? s_in.data_i1_I : s_in.data_i0_I;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sh_R <= '0;
        r_sh_I <= '0;
      end else if (w_we[PAIR]) begin
        r_sh_R <= w_in_R;
        r_sh_I <= w_in_I;
      end
    end

    // The last pair is still in flight on the transfer edge, so those two
    // slots load from the live inputs rather than from the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_bank_R <= '0;
        r_bank_I <= '0;
      end else if (w_xfer) begin
        if (PAIR == 3'(S2P_BEATS - 1)) begin
          r_bank_R <= w_in_R;
          r_bank_I <= w_in_I;
        end else begin
          r_bank_R <= r_sh_R;
          r_bank_I <= r_sh_I;
        end
      end
    end
  end

  assign data_o0_R  = g_slot[0].r_bank_R;   assign data_o0_I  = g_slot[0].r_bank_I;
  assign data_o1_R  = g_slot[1].r_bank_R;   assign data_o1_I  = g_slot[1].r_bank_I;
  assign data_o2_R  = g_slot[2].r_bank_R;   assign data_o2_I  = g_slot[2].r_bank_I;
  assign data_o3_R  = g_slot[3].r_bank_R;   assign data_o3_I  = g_slot[3].r_bank_I;
  assign data_o4_R  = g_slot[4].r_bank_R;   assign data_o4_I  = g_slot[4].r_bank_I;
  assign data_o5_R  = g_slot[5].r_bank_R;   assign data_o5_I  = g_slot[5].r_bank_I;
  assign data_o6_R  = g_slot[6].r_bank_R;   assign data_o6_I  = g_slot[6].r_bank_I;
  assign data_o7_R  = g_slot[7].r_bank_R;   assign data_o7_I  = g_slot[7].r_bank_I;
  assign data_o8_R  = g_slot[8].r_bank_R;   assign data_o8_I  = g_slot[8].r_bank_I;
  assign data_o9_R  = g_slot[9].r_bank_R;   assign data_o9_I  = g_slot[9].r_bank_I;
  assign data_o10_R = g_slot[10].r_bank_R;  assign data_o10_I = g_slot[10].r_bank_I;
  assign data_o11_R = g_slot[11].r_bank_R;  assign data_o11_I = g_slot[11].r_bank_I;
  assign data_o12_R = g_slot[12].r_bank_R;  assign data_o12_I = g_slot[12].r_bank_I;
  assign data_o13_R = g_slot[13].r_bank_R;  assign data_o13_I = g_slot[13].r_bank_I;
  assign data_o14_R = g_slot[14].r_bank_R;  assign data_o14_I = g_slot[14].r_bank_I;
  assign data_o15_R = g_slot[15].r_bank_R;  assign data_o15_I = g_slot[15].r_bank_I;

endmodule

// File: tb/tb_ser2par.sv
// tb_ser2par: directed, table-driven bench for ser2par.
// Frame with base k: beat b carries x[b] = (k+b, k+100+b) and
// x[b+8] = (k+8+b, k+108+b); the assembled bank is x[N] = (k+N, k+100+N).
module tb_ser2par;

  localparam int W = 17;

  typedef struct {
    bit valid;
    bit sof;
    int base;
    int b;
    bit fv;
    bit err;
    int beat;
    int bank;   // expected bank base, -1 = all zeros
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [W-1:0] data_o0_R,  data_o0_I,  data_o1_R,  data_o1_I,  data_o2_R,  data_o2_I;
  logic [W-1:0] data_o3_R,  data_o3_I,  data_o4_R,  data_o4_I,  data_o5_R,  data_o5_I;
  logic [W-1:0] data_o6_R,  data_o6_I,  data_o7_R,  data_o7_I,  data_o8_R,  data_o8_I;
  logic [W-1:0] data_o9_R,  data_o9_I,  data_o10_R, data_o10_I, data_o11_R, data_o11_I;
  logic [W-1:0] data_o12_R, data_o12_I, data_o13_R, data_o13_I, data_o14_R, data_o14_I;
  logic [W-1:0] data_o15_R, data_o15_I;
  logic         frame_valid_o, sof_err_o;
  logic [2:0]   beat_o;

  logic [W-1:0] oR [16];
  logic [W-1:0] oI [16];

  int tests_run    = 0;
  int tests_failed = 0;
  int cur_bank;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ser2par_if #(.WIDTH(W)) bus ();

  ser2par #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .s_in(bus),
    .data_o0_R(data_o0_R),   .data_o0_I(data_o0_I),   .data_o1_R(data_o1_R),   .data_o1_I(data_o1_I),
    .data_o2_R(data_o2_R),   .data_o2_I(data_o2_I),   .data_o3_R(data_o3_R),   .data_o3_I(data_o3_I),
    .data_o4_R(data_o4_R),   .data_o4_I(data_o4_I),   .data_o5_R(data_o5_R),   .data_o5_I(data_o5_I),
    .data_o6_R(data_o6_R),   .data_o6_I(data_o6_I),   .data_o7_R(data_o7_R),   .data_o7_I(data_o7_I),
    .data_o8_R(data_o8_R),   .data_o8_I(data_o8_I),   .data_o9_R(data_o9_R),   .data_o9_I(data_o9_I),
    .data_o10_R(data_o10_R), .data_o10_I(data_o10_I), .data_o11_R(data_o11_R), .data_o11_I(data_o11_I),
    .data_o12_R(data_o12_R), .data_o12_I(data_o12_I), .data_o13_R(data_o13_R), .data_o13_I(data_o13_I),
    .data_o14_R(data_o14_R), .data_o14_I(data_o14_I), .data_o15_R(data_o15_R), .data_o15_I(data_o15_I),
    .frame_valid_o(frame_valid_o), .beat_o(beat_o), .sof_err_o(sof_err_o)
  );

  assign oR[0]  = data_o0_R;  assign oI[0]  = data_o0_I;  assign oR[1]  = data_o1_R;  assign oI[1]  = data_o1_I;
  assign oR[2]  = data_o2_R;  assign oI[2]  = data_o2_I;  assign oR[3]  = data_o3_R;  assign oI[3]  = data_o3_I;
  assign oR[4]  = data_o4_R;  assign oI[4]  = data_o4_I;  assign oR[5]  = data_o5_R;  assign oI[5]  = data_o5_I;
  assign oR[6]  = data_o6_R;  assign oI[6]  = data_o6_I;  assign oR[7]  = data_o7_R;  assign oI[7]  = data_o7_I;
  assign oR[8]  = data_o8_R;  assign oI[8]  = data_o8_I;  assign oR[9]  = data_o9_R;  assign oI[9]  = data_o9_I;
  assign oR[10] = data_o10_R; assign oI[10] = data_o10_I; assign oR[11] = data_o11_R; assign oI[11] = data_o11_I;
  assign oR[12] = data_o12_R; assign oI[12] = data_o12_I; assign oR[13] = data_o13_R; assign oI[13] = data_o13_I;
  assign oR[14] = data_o14_R; assign oI[14] = data_o14_I; assign oR[15] = data_o15_R; assign oI[15] = data_o15_I;

  // ---------------- checking ----------------
  task automatic chk(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic check_bank(input int base);
    int bad_n;
    logic [W-1:0] er, ei;
    bad_n = -1;
    for (int n = 0; n < 16; n++) begin
      er = (base < 0) ? '0 : W'(base + n);
      ei = (base < 0) ? '0 : W'(base + 100 + n);
      if (bad_n < 0 && (oR[n] !== er || oI[n] !== ei)) bad_n = n;
    end
    tests_run++;
    if (bad_n >= 0) begin
      tests_failed++;
      er = (base < 0) ? '0 : W'(base + bad_n);
      ei = (base < 0) ? '0 : W'(base + 100 + bad_n);
      $display("FAIL bank[%0d] @%0t: got R=%0h I=%0h, expected R=%0h I=%0h",
               bad_n, $time, oR[bad_n], oI[bad_n], er, ei);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.valid_i = v.valid;
    bus.sof_i   = v.sof;
    if (v.valid) begin
      bus.data_i0_R = W'(v.base + v.b);
      bus.data_i0_I = W'(v.base + 100 + v.b);
      bus.data_i1_R = W'(v.base + 8 + v.b);
      bus.data_i1_I = W'(v.base + 108 + v.b);
    end else begin
      bus.data_i0_R = '1; bus.data_i0_I = '1;
      bus.data_i1_R = '1; bus.data_i1_I = '1;
    end
    @(posedge clk);
    #1;
    chk("frame_valid", int'(frame_valid_o), int'(v.fv));
    chk("sof_err", int'(sof_err_o), int'(v.err));
    chk("beat", int'(beat_o), v.beat);
    check_bank(v.bank);
  endtask

  // ---------------- table builders ----------------
  function automatic void add_beat(input int base, input int b, input bit sof, input bit err);
    bit fv;
    fv = (b == 7);
    if (fv) cur_bank = base;
    vecs.push_back('{1'b1, sof, base, b, fv, err, fv ? 0 : b + 1, cur_bank});
  endfunction

  function automatic void add_frame(input int base);
    for (int b = 0; b < 8; b++) add_beat(base, b, b == 0, 1'b0);
  endfunction

  // Gaps drive sof high with valid low: sof must be ignored when unqualified.
  function automatic void add_idle(input int n, input int beat);
    for (int i = 0; i < n; i++) vecs.push_back('{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, beat, cur_bank});
  endfunction

  function automatic void add_drop(input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{1'b1, 1'b0, 'h7000, i, 1'b0, 1'b0, 0, cur_bank});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.valid_i = 1'b0; bus.sof_i = 1'b0;
    bus.data_i0_R = '0; bus.data_i0_I = '0; bus.data_i1_R = '0; bus.data_i1_I = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_frame_valid", int'(frame_valid_o), 0);
    chk("rst_beat", int'(beat_o), 0);
    check_bank(-1);
    @(negedge clk);
    rst_n = 1'b1;

    cur_bank = -1;
    add_idle(2, 0);
    // single frame, no gaps
    add_frame(0);
    add_idle(2, 0);
    // gapped frame
    for (int b = 0; b < 3; b++) add_beat('h200, b, b == 0, 1'b0);
    add_idle(3, 3);
    for (int b = 3; b < 6; b++) add_beat('h200, b, 1'b0, 1'b0);
    add_idle(3, 6);
    for (int b = 6; b < 8; b++) add_beat('h200, b, 1'b0, 1'b0);
    add_idle(1, 0);
    // beats before sof are dropped
    add_drop(3);
    add_frame('h400);
    add_idle(1, 0);
    // mid-frame sof: A abandoned after 4 beats, B restarts
    for (int b = 0; b < 4; b++) add_beat('hAA00, b, b == 0, 1'b0);
    add_beat('h1000, 0, 1'b1, 1'b1);
    for (int b = 1; b < 8; b++) add_beat('h1000, b, 1'b0, 1'b0);
    add_idle(1, 0);
    // back-to-back, valid continuously high
    add_frame('h2000);
    add_frame('h3000);

    foreach (vecs[i]) apply(vecs[i]);

    // reset asserted at beat 4 of a third frame
    vecs.delete();
    for (int b = 0; b < 4; b++) add_beat('h4000, b, b == 0, 1'b0);
    foreach (vecs[i]) apply(vecs[i]);
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_beat", int'(beat_o), 0);
    chk("async_rst_frame_valid", int'(frame_valid_o), 0);
    check_bank(-1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold_frame_valid", int'(frame_valid_o), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // recovery after reset
    vecs.delete();
    cur_bank = -1;
    add_idle(1, 0);
    add_frame('h500);
    add_idle(1, 0);
    foreach (vecs[i]) apply(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
